// File: rtl/analog_dir_decoder.sv
// Analog stick to 4-way direction decoder with deadzone, hysteresis and
// tick-based debounce, plus a raw d-pad passthrough mode. One instance per player.
module analog_dir_decoder #(
    parameter int unsigned DEADZONE   = 32,
    parameter int unsigned HYST       = 8,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned SAMPLE_DIV = 1200
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        mode_digital,
    input  logic [3:0]  joy_dig,
    input  logic [15:0] joy_l,
    input  logic [15:0] joy_r,
    output logic [3:0]  run_dir,
    output logic [3:0]  aim_dir,
    output logic        tick
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NAXIS = 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    // Thresholds as 9-bit signed so -128 compares without overflow
    localparam logic signed [8:0] DZ_POS  = 9'(DEADZONE);
    localparam logic signed [8:0] DZ_NEG  = -9'(DEADZONE);
    localparam logic signed [8:0] REL_POS = 9'(DEADZONE - HYST);
    localparam logic signed [8:0] REL_NEG = -9'(DEADZONE - HYST);

    typedef enum logic [1:0] {
        AX_CENTER = 2'd0,
        AX_POS    = 2'd1,
        AX_NEG    = 2'd2
    } axis_e;

    // Axis order: 0 runX, 1 runY, 2 aimX, 3 aimY
    logic [7:0]       axis_v [NAXIS];
    axis_e            st_q   [NAXIS];
    axis_e            st_d   [NAXIS];
    axis_e            cand_q [NAXIS];
    axis_e            cand_d [NAXIS];
    axis_e            tgt    [NAXIS];
    logic [CNT_W-1:0] cnt_q  [NAXIS];
    logic [CNT_W-1:0] cnt_d  [NAXIS];
    logic [CNT_W-1:0] cnt_n  [NAXIS];

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             mode_q;
    logic             mode_change;
    logic [3:0]       run_dir_q, run_dir_d;
    logic [3:0]       aim_dir_q, aim_dir_d;
    logic [3:0]       dig_filt;

    assign axis_v[0] = joy_l[7:0];
    assign axis_v[1] = joy_l[15:8];
    assign axis_v[2] = joy_r[7:0];
    assign axis_v[3] = joy_r[15:8];

    assign mode_change = mode_digital ^ mode_q;

    assign run_dir = run_dir_q;
    assign aim_dir = aim_dir_q;
    assign tick    = tick_q;

    // Target state from the committed state and the current sample
    function automatic axis_e target_of(axis_e cur, logic [7:0] v);
        logic signed [8:0] sv;
        axis_e             t;
        sv = $signed({v[7], v});
        t  = cur;
        case (cur)
            AX_CENTER: begin
                if (sv > DZ_POS)      t = AX_POS;
                else if (sv < DZ_NEG) t = AX_NEG;
                else                  t = AX_CENTER;
            end
            AX_POS:  if (sv < REL_POS) t = AX_CENTER;
            AX_NEG:  if (sv > REL_NEG) t = AX_CENTER;
            default: t = AX_CENTER;
        endcase
        return t;
    endfunction

    // Sample divider; tick register is high while the count sits at its last value
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_d == DIV_LAST);
    end

    // State register: divider, mode history, axis FSMs and outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_q     <= '0;
            tick_q    <= 1'b0;
            mode_q    <= 1'b0;
            run_dir_q <= '0;
            aim_dir_q <= '0;
            for (int unsigned a = 0; a < NAXIS; a++) begin
                st_q[a]   <= AX_CENTER;
                cand_q[a] <= AX_CENTER;
                cnt_q[a]  <= '0;
            end
        end else begin
            div_q     <= div_d;
            tick_q    <= tick_d;
            mode_q    <= mode_digital;
            run_dir_q <= run_dir_d;
            aim_dir_q <= aim_dir_d;
            for (int unsigned a = 0; a < NAXIS; a++) begin
                st_q[a]   <= st_d[a];
                cand_q[a] <= cand_d[a];
                cnt_q[a]  <= cnt_d[a];
            end
        end
    end

    // Next-state: per-axis target and debounce, advanced only on analog ticks
    always_comb begin
        for (int unsigned a = 0; a < NAXIS; a++) begin
            st_d[a]   = st_q[a];
            cand_d[a] = cand_q[a];
            cnt_d[a]  = cnt_q[a];
            cnt_n[a]  = '0;
            tgt[a]    = target_of(st_q[a], axis_v[a]);
            if (mode_change) begin
                st_d[a]   = AX_CENTER;
                cand_d[a] = AX_CENTER;
                cnt_d[a]  = '0;
            end else if (tick_q && !mode_digital) begin
                if (tgt[a] == st_q[a]) begin
                    cnt_d[a] = '0;
                end else begin
                    if (tgt[a] != cand_q[a]) begin
                        cand_d[a] = tgt[a];
                        cnt_n[a]  = CNT_W'(1);
                    end else begin
                        cnt_n[a]  = cnt_q[a] + CNT_W'(1);
                    end
                    if (cnt_n[a] >= CNT_W'(STABLE_CNT)) begin
                        st_d[a]  = cand_d[a];
                        cnt_d[a] = '0;
                    end else begin
                        cnt_d[a] = cnt_n[a];
                    end
                end
            end
        end
    end

    // Output decode: blank on mode change, filtered d-pad, or committed axis states
    always_comb begin
        dig_filt = joy_dig;
        if (joy_dig[3] && joy_dig[2]) dig_filt[3:2] = 2'b00;
        if (joy_dig[1] && joy_dig[0]) dig_filt[1:0] = 2'b00;
        run_dir_d = '0;
        aim_dir_d = '0;
        if (mode_change) begin
            run_dir_d = '0;
            aim_dir_d = '0;
        end else if (mode_digital) begin
            run_dir_d = dig_filt;
            aim_dir_d = dig_filt;
        end else begin
            run_dir_d = {st_d[1] == AX_NEG, st_d[1] == AX_POS,
                         st_d[0] == AX_NEG, st_d[0] == AX_POS};
            aim_dir_d = {st_d[3] == AX_NEG, st_d[3] == AX_POS,
                         st_d[2] == AX_NEG, st_d[2] == AX_POS};
        end
    end

endmodule

// File: tb/tb_analog_dir_decoder.sv
// Bench for analog_dir_decoder: directed scenarios plus randomized segments,
// compared every cycle against a tick-level behavioural model.
module tb_analog_dir_decoder;

    localparam int SD = 1200;
    localparam int DZ = 32;
    localparam int HY = 8;
    localparam int SC = 4;

    logic        clk_sys;
    logic        reset;
    logic        mode_digital;
    logic [3:0]  joy_dig;
    logic [15:0] joy_l;
    logic [15:0] joy_r;
    logic [3:0]  run_dir;
    logic [3:0]  aim_dir;
    logic        tick;

    analog_dir_decoder dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .mode_digital (mode_digital),
        .joy_dig      (joy_dig),
        .joy_l        (joy_l),
        .joy_r        (joy_r),
        .run_dir      (run_dir),
        .aim_dir      (aim_dir),
        .tick         (tick)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Model state: axis states as -1/0/+1
    int         mdiv;
    bit         mmode;
    int         com  [4];
    int         cand [4];
    int         cnt  [4];
    logic [3:0] e_run;
    logic [3:0] e_aim;
    logic       e_tick;
    bit         ticked;
    longint     cyc;
    longint     last_tick_cyc;
    bit         have_tick;

    function automatic int target(int cur, logic [7:0] b);
        int v;
        v = int'($signed(b));
        if (cur == 0) return (v > DZ) ? 1 : ((v < -DZ) ? -1 : 0);
        if (cur == 1) return (v < DZ - HY) ? 0 : 1;
        return (v > -(DZ - HY)) ? 0 : -1;
    endfunction

    function automatic logic [3:0] dirs(int x, int y);
        return {y == -1, y == 1, x == -1, x == 1};
    endfunction

    function automatic logic [3:0] filt(logic [3:0] d);
        logic [3:0] r;
        r = d;
        if (d[3] && d[2]) r[3:2] = 2'b00;
        if (d[1] && d[0]) r[1:0] = 2'b00;
        return r;
    endfunction

    function automatic logic [7:0] pick_val();
        case ($urandom_range(0, 15))
            0:  return 8'h80;   // -128
            1:  return 8'h9C;   // -100
            2:  return 8'hDF;   // -33
            3:  return 8'hE0;   // -32
            4:  return 8'hE7;   // -25
            5:  return 8'hE8;   // -24
            6:  return 8'h00;
            7:  return 8'd23;
            8:  return 8'd24;
            9:  return 8'd25;
            10: return 8'd32;
            11: return 8'd33;
            12: return 8'd100;
            13: return 8'd127;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear_axes();
        for (int a = 0; a < 4; a++) begin
            com[a] = 0; cand[a] = 0; cnt[a] = 0;
        end
    endtask

    // One clock: advance model on current inputs, clock DUT, compare outputs
    task automatic clk_step();
        logic [7:0] v [4];
        int t;
        v[0] = joy_l[7:0];  v[1] = joy_l[15:8];
        v[2] = joy_r[7:0];  v[3] = joy_r[15:8];
        ticked = 1'b0;
        if (reset) begin
            mdiv = 0; mmode = 1'b0; have_tick = 1'b0;
            model_clear_axes();
            e_run = '0; e_aim = '0;
        end else begin
            if (mode_digital != mmode) begin
                model_clear_axes();
                e_run = '0; e_aim = '0;
            end else if (mode_digital) begin
                e_run = filt(joy_dig);
                e_aim = filt(joy_dig);
            end else begin
                if (mdiv == SD - 1) begin
                    for (int a = 0; a < 4; a++) begin
                        t = target(com[a], v[a]);
                        if (t == com[a]) cnt[a] = 0;
                        else begin
                            if (t != cand[a]) begin cand[a] = t; cnt[a] = 1; end
                            else cnt[a]++;
                            if (cnt[a] == SC) begin com[a] = cand[a]; cnt[a] = 0; end
                        end
                    end
                end
                e_run = dirs(com[0], com[1]);
                e_aim = dirs(com[2], com[3]);
            end
            ticked = (mdiv == SD - 1);
            mdiv   = (mdiv + 1) % SD;
            mmode  = mode_digital;
        end
        e_tick = (mdiv == SD - 1);
        @(posedge clk_sys);
        #1;
        cyc++;
        chk("run_dir", 32'(run_dir), 32'(e_run));
        chk("aim_dir", 32'(aim_dir), 32'(e_aim));
        chk("tick",    32'(tick),    32'(e_tick));
        if (tick === 1'b1) begin
            if (have_tick) chk("tick_period", 32'(cyc - last_tick_cyc), 32'(SD));
            last_tick_cyc = cyc;
            have_tick     = 1'b1;
        end
    endtask

    task automatic step_n(int n);
        repeat (n) clk_step();
    endtask

    // Return just after the edge that closes the n-th tick cycle
    task automatic step_ticks(int n);
        int k;
        k = 0;
        while (k < n) begin
            clk_step();
            if (ticked) k++;
        end
    endtask

    // Return while the current cycle is a tick cycle
    task automatic step_to_tick_cycle();
        while (mdiv != SD - 1) clk_step();
    endtask

    initial begin
        cyc = 0; last_tick_cyc = 0; have_tick = 1'b0;
        mdiv = 0; mmode = 1'b0;
        model_clear_axes();
        reset = 1'b1; mode_digital = 1'b0; joy_dig = '0; joy_l = '0; joy_r = '0;
        step_n(3);
        chk("rst_run",  32'(run_dir), 32'h0);
        chk("rst_aim",  32'(aim_dir), 32'h0);
        chk("rst_tick", 32'(tick),    32'h0);
        reset = 1'b0;
        step_n(5);

        // Run X=+100 commits right after the 4th tick
        joy_l = {8'h00, 8'd100};
        step_ticks(3);
        step_to_tick_cycle();
        chk("t1_pre_commit", 32'(run_dir), 32'h0);
        clk_step();
        chk("t1_commit", 32'(run_dir), 32'b0001);
        chk("t1_aim",    32'(aim_dir), 32'h0);

        // Hysteresis band holds, below band releases after 4 ticks
        joy_l = {8'h00, 8'd30};
        step_ticks(5);
        chk("t2_hyst_hold", 32'(run_dir), 32'b0001);
        joy_l = {8'h00, 8'd20};
        step_ticks(3);
        step_to_tick_cycle();
        chk("t2_pre_release", 32'(run_dir), 32'b0001);
        clk_step();
        chk("t2_release", 32'(run_dir), 32'b0000);

        // Alternating input never commits
        for (int i = 0; i < 6; i++) begin
            joy_l = (i % 2 == 0) ? {8'h00, 8'd100} : 16'h0000;
            step_ticks(1);
            chk("t3_alternate", 32'(run_dir), 32'h0);
        end
        joy_l = '0;

        // Aim full-scale negative, then Y swing through centre
        joy_r = {8'h80, 8'h80};
        step_ticks(4);
        chk("t4_aim_neg", 32'(aim_dir), 32'b1010);
        joy_r = {8'h7F, 8'h80};
        step_ticks(4);
        chk("t4_aim_center_y", 32'(aim_dir), 32'b0010);
        step_ticks(4);
        chk("t4_aim_pos_y", 32'(aim_dir), 32'b0110);
        chk("t4_run", 32'(run_dir), 32'h0);

        // Digital passthrough with opposite-bit suppression
        mode_digital = 1'b1; joy_dig = 4'b0011;
        clk_step();
        chk("t5_change_run", 32'(run_dir), 32'h0);
        clk_step();
        chk("t5_lr_run", 32'(run_dir), 32'h0);
        chk("t5_lr_aim", 32'(aim_dir), 32'h0);
        joy_dig = 4'b1001;
        clk_step();
        chk("t5_dig_run", 32'(run_dir), 32'b1001);
        chk("t5_dig_aim", 32'(aim_dir), 32'b1001);
        joy_dig = 4'b1110;
        clk_step();
        chk("t5_ud_run", 32'(run_dir), 32'b0010);

        // Mode toggles blank outputs and restart the analog debounce
        mode_digital = 1'b0; joy_dig = '0; joy_r = '0; joy_l = {8'h00, 8'd100};
        clk_step();
        chk("t6_change_a", 32'(run_dir), 32'h0);
        step_ticks(4);
        chk("t6_commit", 32'(run_dir), 32'b0001);
        mode_digital = 1'b1;
        clk_step();
        chk("t6_to_dig", 32'(run_dir), 32'h0);
        clk_step();
        mode_digital = 1'b0;
        clk_step();
        chk("t6_to_ana", 32'(run_dir), 32'h0);
        step_ticks(3);
        step_to_tick_cycle();
        chk("t6_pre_recommit", 32'(run_dir), 32'h0);
        clk_step();
        chk("t6_recommit", 32'(run_dir), 32'b0001);

        // Reset mid-count
        joy_l = {8'h00, 8'd20}; joy_r = {8'h80, 8'h00};
        step_ticks(2);
        reset = 1'b1;
        clk_step();
        chk("t7_rst_run",  32'(run_dir), 32'h0);
        chk("t7_rst_aim",  32'(aim_dir), 32'h0);
        chk("t7_rst_tick", 32'(tick),    32'h0);
        reset = 1'b0;
        joy_l = '0; joy_r = '0;
        step_n(4);

        // Randomized segments
        for (int s = 0; s < 8; s++) begin
            joy_l   = {pick_val(), pick_val()};
            joy_r   = {pick_val(), pick_val()};
            joy_dig = 4'($urandom);
            if ($urandom_range(0, 7) == 0) mode_digital = ~mode_digital;
            step_n(int'($urandom_range(300, 3000)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/analog_dir_decoder.md
Name: analog_dir_decoder

Overview:
- Input-conditioning stage between hps_io joystick outputs and the williams2 core's btn_run_N/btn_aim_N inputs; one instance per player.
- Converts the signed 8-bit analog stick axes (left stick → run, right stick → aim) into 4-bit {up,down,left,right} direction words.
- Uses deadzone, hysteresis and sample-count debounce; a mode input selects raw digital d-pad passthrough instead.

Parameters:
DEADZONE, 32, signed threshold magnitude (1..126) an axis must exceed to leave centre
HYST, 8, hysteresis band; an active axis returns to centre only below DEADZONE-HYST in magnitude (HYST < DEADZONE)
STABLE_CNT, 4, consecutive sample ticks a new axis state must persist before it is committed (1..15)
SAMPLE_DIV, 1200, clk_sys cycles per sample tick (12 MHz / 1200 = 10 kHz)

Ports:
clk_sys  in  1  system clock (12 MHz)
reset  in  1  synchronous, active-high reset
mode_digital  in  1  1 = d-pad passthrough, 0 = analog decode
joy_dig  in  4  d-pad bits {up,down,left,right} (joystick_N[3:0] reordered)
joy_l  in  16  left-stick analog: [7:0] X, [15:8] Y, two's complement, +X right, +Y down
joy_r  in  16  right-stick analog, same format
run_dir  out  4  {up,down,left,right} to btn_run_N
aim_dir  out  4  {up,down,left,right} to btn_aim_N
tick  out  1  one-cycle sample strobe (debug/verification)

Behaviour:
- Reset: run_dir=0, aim_dir=0, tick=0, divider=0, all four axis FSMs in CENTER, all candidate/stability counters cleared.
- Divider counts 0..SAMPLE_DIV-1 and wraps; tick=1 for exactly the cycle in which the count equals SAMPLE_DIV-1. Axis FSMs and counters advance only on tick cycles.
- Four independent axis units: runX, runY (joy_l), aimX, aimY (joy_r). Each holds a committed state in {NEG, CENTER, POS}.
- Target state per axis, computed on each tick with signed 8-bit compares:
  - From CENTER: POS if v > DEADZONE; NEG if v < -DEADZONE; else CENTER.
  - From POS: CENTER if v < DEADZONE-HYST. A POS→NEG swing passes through CENTER first and needs two commits.
  - From NEG: CENTER if v > -(DEADZONE-HYST); otherwise stays NEG.
  - -128 is a valid full-scale NEG input; no overflow, since compares are done sign-extended to 9 bits.
- Debounce:
  - If target == committed, the stability counter clears.
  - If target differs from the current candidate, candidate := target and counter := 1.
  - If target equals the candidate, the counter increments.
  - When the counter reaches STABLE_CNT, committed := candidate and the counter clears. With STABLE_CNT=1, the state commits on the first differing tick.
- Output mapping (analog mode):
  - right = X is POS; left = X is NEG; down = Y is POS; up = Y is NEG.
  - Registered from the committed states, so outputs change on the cycle after the committing tick.
  - Opposite bits are never both set by construction.
- Digital mode:
  - run_dir and aim_dir both equal joy_dig registered (1-cycle latency), independent of tick.
  - If left and right are both set, both are output 0; same rule for up and down.
- Mode change (either edge of mode_digital, detected by registering mode_digital):
  - On the change cycle, all axis FSMs are forced to CENTER and counters cleared; run_dir and aim_dir are 0 for that cycle.
  - The divider is not reset.
- Reset asserted mid-operation has full priority and returns every state to its reset value on the next edge.

Test Plan:
- Reset, then mode_digital=0, joy_l X=+100, all else 0 → run_dir=4'b0001 exactly 1 cycle after the 4th tick following the input change; aim_dir=0 throughout; tick period exactly 1200 cycles.
- X held at +100 until committed, then X=+30 → stays 0001 (inside the hysteresis band); then X=+20 → returns to 0000 after 4 ticks.
- X alternates +100 / 0 on every tick → run_dir never leaves 0000 (the counter keeps restarting).
- joy_r Y=-128, X=-128 → aim_dir=4'b1010 after 4 ticks; then Y=+127 → 4 ticks to CENTER (aim_dir=0010), then 4 more ticks to 0110.
- mode_digital=1, joy_dig=4'b0011 → both outputs 4'b0000 next cycle; joy_dig=4'b1001 → both outputs 1001 next cycle, with no tick dependency.
- Analog run committed at 0001, toggle mode_digital to 1 then back to 0 with X still +100 → outputs 0 on each change cycle; analog 0001 re-commits only 4 ticks later. Separately, assert reset mid-count → all outputs 0 next cycle.
